// File: rtl/regfile_wr_arbiter_pkg.sv
// regfile_wr_arbiter_pkg
// Shared widths and the grant encoding for the register-file write arbiter.
//   REG_AW : register address width (x0..x31)
//   XLEN   : register data width
//   CNT_W  : width of the stall and drop statistics counters
//   grant_e: identifies which requester received the most recent grant
package regfile_wr_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    GRANT_WB  = 1'b0,
    GRANT_ALU = 1'b1
  } grant_e;

endpackage : regfile_wr_arbiter_pkg

// File: rtl/regfile_wr_arbiter_sat_counter.sv
// sat_counter
// Saturating up-counter. It adds 'inc' each cycle and sticks at all-ones
// instead of wrapping. 'clr' has priority and returns the count to zero.
// Ports:
//   clk   : clock, rising edge
//   clr   : synchronous clear, active high
//   inc   : increment amount for this cycle (0 means hold)
//   count : current count
module sat_counter #(
  parameter int WIDTH = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH:0]   sum;

  // One extra bit catches the carry out; any carry means we passed the top.
  assign sum = {1'b0, count_reg} + {{(WIDTH + 1 - INC_W){1'b0}}, inc};

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (sum[WIDTH]) begin
      count_reg <= '1;
    end else begin
      count_reg <= sum[WIDTH-1:0];
    end
  end

  assign count = count_reg;

endmodule : sat_counter

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Merges the ALU and load-writeback result streams onto the single
// register-file write port.
//   - One valid requester is accepted immediately.
//   - Two requesters for different registers are served round-robin; the
//     loser waits exactly one cycle.
//   - Two requesters for the same register are both accepted; only the
//     (younger) ALU value is written and the writeback value is dropped.
//   - Writes to x0 are accepted but never issued.
//   - Accepted writes appear on rf_we/rf_waddr/rf_wdata one cycle later.
// Optional feature: define REGWR_BYPASS_EN to add a two-port forwarding
// view of the write currently on the register-file port.
// Ports:
//   clk, rst                      : clock and synchronous active-high reset
//   alu_valid/rd/data, alu_ready  : ALU result requester
//   wb_valid/rd/data,  wb_ready   : load-writeback requester
//   rf_we, rf_waddr, rf_wdata     : registered register-file write port
//   stall_cnt                     : cycles with a valid but not-ready requester
//   drop_cnt                      : accepted writes that were not issued
//   byp_rs1/2, byp1/2_hit/data    : forwarding taps (REGWR_BYPASS_EN only)
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef REGWR_BYPASS_EN
  input  logic [REG_AW-1:0] byp_rs1,
  input  logic [REG_AW-1:0] byp_rs2,
  output logic              byp1_hit,
  output logic [XLEN-1:0]   byp1_data,
  output logic              byp2_hit,
  output logic [XLEN-1:0]   byp2_data,
`endif
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              wb_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  grant_e            last_grant_reg, last_grant_next;
  logic              rf_we_reg, rf_we_next;
  logic [REG_AW-1:0] rf_waddr_reg, rf_waddr_next;
  logic [XLEN-1:0]   rf_wdata_reg, rf_wdata_next;

  logic              same_rd;
  logic              alu_acc, wb_acc;
  logic              stall_inc;
  logic [1:0]        drop_inc;

  assign same_rd = (alu_rd == wb_rd);

  // A requester is blocked only when the other one is valid, targets a
  // different register, and it is that other requester's turn.
  assign alu_ready = !rst && (!wb_valid  || same_rd || (last_grant_reg == GRANT_WB));
  assign wb_ready  = !rst && (!alu_valid || same_rd || (last_grant_reg == GRANT_ALU));

  assign alu_acc = alu_valid && alu_ready;
  assign wb_acc  = wb_valid  && wb_ready;

  assign stall_inc = (alu_valid && !alu_ready) || (wb_valid && !wb_ready);

  // Drops: each accepted x0 write, plus the writeback value whenever it is
  // shadowed by a same-register ALU write. Both together on x0 give 2.
  assign drop_inc = {1'b0, (alu_acc && (alu_rd == '0))}
                  + {1'b0, (wb_acc && ((wb_rd == '0) || alu_acc))};

  always_comb begin
    last_grant_next = last_grant_reg;
    rf_we_next      = 1'b0;
    rf_waddr_next   = rf_waddr_reg;
    rf_wdata_next   = rf_wdata_reg;
    // ALU wins whenever accepted: it is either alone, on its turn, or the
    // younger value in a same-register collision.
    if (alu_acc) begin
      last_grant_next = GRANT_ALU;
      if (alu_rd != '0) begin
        rf_we_next    = 1'b1;
        rf_waddr_next = alu_rd;
        rf_wdata_next = alu_data;
      end
    end else if (wb_acc) begin
      last_grant_next = GRANT_WB;
      if (wb_rd != '0) begin
        rf_we_next    = 1'b1;
        rf_waddr_next = wb_rd;
        rf_wdata_next = wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= GRANT_WB;
      rf_we_reg      <= 1'b0;
      rf_waddr_reg   <= '0;
      rf_wdata_reg   <= '0;
    end else begin
      last_grant_reg <= last_grant_next;
      rf_we_reg      <= rf_we_next;
      rf_waddr_reg   <= rf_waddr_next;
      rf_wdata_reg   <= rf_wdata_next;
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;

  sat_counter #(.WIDTH(CNT_W), .INC_W(1)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W), .INC_W(2)) u_drop_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

`ifdef REGWR_BYPASS_EN
  // x0 never forwards: it reads as zero regardless of any write.
  assign byp1_hit  = rf_we_reg && (rf_waddr_reg == byp_rs1) && (byp_rs1 != '0);
  assign byp2_hit  = rf_we_reg && (rf_waddr_reg == byp_rs2) && (byp_rs2 != '0);
  assign byp1_data = rf_wdata_reg;
  assign byp2_data = rf_wdata_reg;
`endif

endmodule : regfile_wr_arbiter

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter
// Directed scenarios plus a randomized run against a cycle-level reference
// model of the arbitration rules. Also exercises the saturation boundary of
// sat_counter on a narrow stand-alone instance.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, wb_valid;
  logic [4:0]  alu_rd, wb_rd;
  logic [31:0] alu_data, wb_data;
  logic        alu_ready, wb_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] stall_cnt, drop_cnt;
`ifdef REGWR_BYPASS_EN
  logic [4:0]  byp_rs1, byp_rs2;
  logic        byp1_hit, byp2_hit;
  logic [31:0] byp1_data, byp2_data;
`endif

  logic        sc_clr;
  logic [1:0]  sc_inc;
  logic [3:0]  sc_count;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
`ifdef REGWR_BYPASS_EN
    .byp_rs1   (byp_rs1),
    .byp_rs2   (byp_rs2),
    .byp1_hit  (byp1_hit),
    .byp1_data (byp1_data),
    .byp2_hit  (byp2_hit),
    .byp2_data (byp2_data),
`endif
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_ready  (wb_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .stall_cnt (stall_cnt),
    .drop_cnt  (drop_cnt)
  );

  sat_counter #(.WIDTH(4), .INC_W(2)) u_sc (
    .clk   (clk),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .count (sc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    wb_valid  = 1'b0; wb_rd  = '0; wb_data  = '0;
  endtask

  // Leaves the bench at a falling edge with rst low and the DUT freshly reset.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    wb_valid  = 1'b1; wb_rd  = 5'd2; wb_data  = 32'h2;
    #1;
    n_checks++;
    if (alu_ready !== 1'b0 || wb_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: alu_ready=%b wb_ready=%b expected 0 0", alu_ready, wb_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 ||
        stall_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: we=%b waddr=%0d wdata=%h stall=%0d drop=%0d expected all 0",
               rf_we, rf_waddr, rf_wdata, stall_cnt, drop_cnt);
    end
    $display("txn reset: we=%b stall=%0d drop=%0d", rf_we, stall_cnt, drop_cnt);
    do_reset();
  endtask

  task automatic test_single_alu();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_alu_ready: got %b expected 1", alu_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL single_alu_write: we=%b waddr=%0d wdata=%h stall=%0d expected 1 5 deadbeef 0",
               rf_we, rf_waddr, rf_wdata, stall_cnt);
    end
    $display("txn single_alu: x%0d=%h", rf_waddr, rf_wdata);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_both_valid();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    wb_valid  = 1'b1; wb_rd  = 5'd4; wb_data  = 32'h22;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1 || wb_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL both_first_grant: alu_ready=%b wb_ready=%b expected 1 0", alu_ready, wb_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin
      n_fail++;
      $display("FAIL both_write1: we=%b waddr=%0d wdata=%h expected 1 3 11", rf_we, rf_waddr, rf_wdata);
    end
    @(negedge clk);
    alu_valid = 1'b0;
    #1;
    n_checks++;
    if (wb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL both_second_grant: wb_ready=%b expected 1", wb_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22 || stall_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL both_write2: we=%b waddr=%0d wdata=%h stall=%0d expected 1 4 22 1",
               rf_we, rf_waddr, rf_wdata, stall_cnt);
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd4 || rf_wdata !== 32'h22) begin
      n_fail++;
      $display("FAIL idle_hold: we=%b waddr=%0d wdata=%h expected 0 4 22", rf_we, rf_waddr, rf_wdata);
    end
    $display("txn both_valid: stall=%0d", stall_cnt);
  endtask

  task automatic test_same_rd();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
    wb_valid  = 1'b1; wb_rd  = 5'd7; wb_data  = 32'hB;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1 || wb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_rd_ready: alu_ready=%b wb_ready=%b expected 1 1", alu_ready, wb_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA || drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL same_rd_write: we=%b waddr=%0d wdata=%h drop=%0d expected 1 7 a 1",
               rf_we, rf_waddr, rf_wdata, drop_cnt);
    end
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL same_rd_single: we=%b expected 0 (only one write)", rf_we);
    end
    $display("txn same_rd: drop=%0d", drop_cnt);
  endtask

  task automatic test_x0();
    do_reset();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h5;
    #1;
    n_checks++;
    if (wb_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL x0_ready: wb_ready=%b expected 1", wb_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0 || drop_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL x0_drop: we=%b drop=%0d expected 0 1", rf_we, drop_cnt);
    end
    @(negedge clk);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h6;
    wb_valid  = 1'b1; wb_rd  = 5'd0; wb_data  = 32'h7;
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0 || drop_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL x0_collision: we=%b drop=%0d expected 0 3", rf_we, drop_cnt);
    end
    $display("txn x0: drop=%0d", drop_cnt);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h100;
    wb_valid  = 1'b1; wb_rd  = 5'd2; wb_data  = 32'h200;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (alu_ready !== 1'b0 || wb_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_ready: alu_ready=%b wb_ready=%b expected 0 0", alu_ready, wb_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b0 || stall_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset_state: we=%b stall=%0d drop=%0d expected 0 0 0", rf_we, stall_cnt, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (alu_ready !== 1'b1 || wb_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_regrant: alu_ready=%b wb_ready=%b expected 1 0", alu_ready, wb_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h100) begin
      n_fail++;
      $display("FAIL mid_reset_write: we=%b waddr=%0d wdata=%h expected 1 1 100", rf_we, rf_waddr, rf_wdata);
    end
    $display("txn reset_mid_stall: x%0d=%h", rf_waddr, rf_wdata);
    @(negedge clk);
    idle_inputs();
  endtask

`ifdef REGWR_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    byp_rs1 = 5'd0; byp_rs2 = 5'd0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1234;
    @(negedge clk);
    idle_inputs();
    byp_rs1 = 5'd9; byp_rs2 = 5'd0;
    #1;
    n_checks++;
    if (byp1_hit !== 1'b1 || byp1_data !== 32'h1234 || byp2_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL bypass: hit1=%b data1=%h hit2=%b expected 1 1234 0", byp1_hit, byp1_data, byp2_hit);
    end
    $display("txn bypass: hit1=%b hit2=%b", byp1_hit, byp2_hit);
  endtask
`endif

  task automatic test_saturation();
    @(negedge clk);
    sc_clr = 1'b1; sc_inc = 2'd0;
    @(negedge clk);
    sc_clr = 1'b0; sc_inc = 2'd1;
    repeat (14) @(negedge clk);
    n_checks++;
    if (sc_count !== 4'd14) begin
      n_fail++;
      $display("FAIL sat_count14: got %0d expected 14", sc_count);
    end
    sc_inc = 2'd2;
    @(negedge clk);
    n_checks++;
    if (sc_count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_inc2_top: got %0d expected 15", sc_count);
    end
    sc_inc = 2'd1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sc_count !== 4'd15) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d expected 15", sc_count);
    end
    sc_clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sc_count !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_clr: got %0d expected 0", sc_count);
    end
    sc_clr = 1'b0; sc_inc = 2'd0;
    $display("txn saturation: count=%0d", sc_count);
  endtask

  // Randomized traffic. Each requester keeps its request until accepted,
  // then may issue a new one. The model applies the arbitration rules
  // directly and keeps counters as plain integers.
  task automatic test_random();
    bit          a_v, w_v, a_acc, w_acc, e_ar, e_wr, m_last_alu, m_we;
    logic [4:0]  a_rd, w_rd, m_waddr;
    logic [31:0] a_d, w_d, m_wdata;
    int          m_stall, m_drop;
    do_reset();
    a_v = 0; w_v = 0; a_rd = 0; w_rd = 0; a_d = 0; w_d = 0;
    m_last_alu = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_stall = 0; m_drop = 0;
    for (int c = 0; c < 300; c++) begin
      if (c != 0) @(negedge clk);
      if (!a_v && $urandom_range(0, 2) != 0) begin
        a_v = 1; a_rd = 5'($urandom_range(0, 7)); a_d = $urandom;
      end
      if (!w_v && $urandom_range(0, 2) != 0) begin
        w_v = 1; w_rd = 5'($urandom_range(0, 7)); w_d = $urandom;
      end
      alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
      wb_valid  = w_v; wb_rd  = w_rd; wb_data  = w_d;
      #1;
      if (a_v && w_v && a_rd != w_rd) begin
        e_ar = !m_last_alu; e_wr = m_last_alu;
      end else begin
        e_ar = a_v; e_wr = w_v;
      end
      if (a_v) begin
        n_checks++;
        if (alu_ready !== e_ar) begin
          n_fail++;
          $display("FAIL rand_alu_ready c=%0d: got %b expected %b", c, alu_ready, e_ar);
        end
      end
      if (w_v) begin
        n_checks++;
        if (wb_ready !== e_wr) begin
          n_fail++;
          $display("FAIL rand_wb_ready c=%0d: got %b expected %b", c, wb_ready, e_wr);
        end
      end
      a_acc = a_v && e_ar;
      w_acc = w_v && e_wr;
      if ((a_v && !e_ar) || (w_v && !e_wr)) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
      if (a_acc && a_rd == 0) m_drop++;
      if (w_acc && w_rd == 0) m_drop++;
      if (a_acc && w_acc && a_rd != 0) m_drop++;
      if (m_drop > 65535) m_drop = 65535;
      m_we = 0;
      if (a_acc) begin
        m_last_alu = 1;
        if (a_rd != 0) begin m_we = 1; m_waddr = a_rd; m_wdata = a_d; end
      end else if (w_acc) begin
        m_last_alu = 0;
        if (w_rd != 0) begin m_we = 1; m_waddr = w_rd; m_wdata = w_d; end
      end
      @(posedge clk); #1;
      n_checks++;
      if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        n_fail++;
        $display("FAIL rand_write c=%0d: got we=%b x%0d=%h expected we=%b x%0d=%h",
                 c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
      end
      n_checks++;
      if (stall_cnt !== 16'(m_stall) || drop_cnt !== 16'(m_drop)) begin
        n_fail++;
        $display("FAIL rand_counters c=%0d: got stall=%0d drop=%0d expected stall=%0d drop=%0d",
                 c, stall_cnt, drop_cnt, m_stall, m_drop);
      end
      if (a_acc || w_acc)
        $display("txn rand %0d: alu_acc=%b wb_acc=%b we=%b x%0d=%h", c, a_acc, w_acc, rf_we, rf_waddr, rf_wdata);
      if (a_acc) a_v = 0;
      if (w_acc) w_v = 0;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    sc_clr = 1'b1;
    sc_inc = 2'd0;
    idle_inputs();
`ifdef REGWR_BYPASS_EN
    byp_rs1 = '0;
    byp_rs2 = '0;
`endif
    test_reset();
    test_single_alu();
    test_both_valid();
    test_same_rd();
    test_x0();
    test_reset_mid_stall();
`ifdef REGWR_BYPASS_EN
    test_bypass();
`endif
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wr_arbiter
